// File: rtl/seq_pattern_tx.sv
// Bit-serial frame transmitter: sync preamble, then payload MSB-first, then an idle gap.
// All outputs are registered; each serial bit is held for BIT_DIV clock cycles.
module seq_pattern_tx #(
  parameter int unsigned      DATA_W   = 8,
  parameter int unsigned      PRE_W    = 3,
  parameter logic [PRE_W-1:0] PREAMBLE = 3'b101,
  parameter int unsigned      GAP_BITS = 2,
  parameter int unsigned      BIT_DIV  = 1,
  parameter logic             IDLE_LVL = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              x_out,
  output logic              x_en,
  output logic              busy,
  output logic              frame_done
);

  // The first preamble bit goes straight to x_out at acceptance, so only the rest is held.
  localparam int unsigned RW       = PRE_W + DATA_W - 1;
  localparam int unsigned MAX_PD   = (PRE_W > DATA_W) ? PRE_W : DATA_W;
  localparam int unsigned MAX_BITS = (MAX_PD > GAP_BITS) ? MAX_PD : GAP_BITS;
  localparam int unsigned CW       = $clog2(MAX_BITS + 1);
  localparam int unsigned DW       = $clog2(BIT_DIV + 1);

  localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_W - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam logic [DW-1:0] DIV_LAST  = DW'(BIT_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_GAP} state_e;

  state_e          state_q;
  logic [RW-1:0]   frame_q;
  logic [CW-1:0]   bit_q;
  logic [DW-1:0]   div_q;
  logic            x_out_q, x_en_q, busy_q, frame_done_q, in_ready_q;

  logic [CW-1:0]   bit_inc;
  logic [DW-1:0]   div_inc;
  logic            final_bit;
  logic            next_final;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    bit_inc    = bit_q + 1'b1;
    div_inc    = div_q + 1'b1;
    final_bit  = 1'b0;
    next_final = 1'b0;
    unique case (state_q)
      S_PRE:  next_final = (bit_q == PRE_LAST) && (GAP_BITS == 0) && (DATA_W == 1);
      S_DATA: begin
        if (GAP_BITS == 0) begin
          final_bit  = (bit_q == DATA_LAST);
          next_final = (bit_inc == DATA_LAST);
        end else begin
          next_final = (bit_q == DATA_LAST) && (GAP_BITS == 1);
        end
      end
      S_GAP: begin
        final_bit  = (bit_q == GAP_LAST);
        next_final = (bit_inc == GAP_LAST);
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; later assignments in the
  // same edge override earlier ones, which the bit-advance overrides below rely on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      // NOTE: the payload register is reset too, so an aborted word cannot leak out later.
      frame_q      <= '0;
      bit_q        <= '0;
      div_q        <= '0;
      x_out_q      <= IDLE_LVL;
      x_en_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      x_en_q       <= 1'b0;
      frame_done_q <= 1'b0;
      if (state_q == S_IDLE) begin
        if (in_valid && in_ready_q) begin
          state_q    <= S_PRE;
          frame_q    <= RW'({PREAMBLE, in_data});
          bit_q      <= '0;
          div_q      <= '0;
          x_out_q    <= PREAMBLE[PRE_W-1];
          x_en_q     <= 1'b1;
          busy_q     <= 1'b1;
          in_ready_q <= 1'b0;
        end
      end else if (div_q != DIV_LAST) begin
        div_q        <= div_inc;
        frame_done_q <= final_bit && (div_inc == DIV_LAST);
      end else begin
        // Last cycle of the current bit: move to the next bit of the frame.
        div_q        <= '0;
        x_en_q       <= 1'b1;
        bit_q        <= bit_inc;
        frame_q      <= frame_q << 1;
        frame_done_q <= (BIT_DIV == 1) && next_final;
        unique case (state_q)
          S_PRE: begin
            x_out_q <= frame_q[RW-1];
            if (bit_q == PRE_LAST) begin
              state_q <= S_DATA;
              bit_q   <= '0;
            end
          end
          S_DATA: begin
            x_out_q <= frame_q[RW-1];
            if (bit_q == DATA_LAST) begin
              bit_q   <= '0;
              x_out_q <= IDLE_LVL;
              if (GAP_BITS == 0) begin
                state_q    <= S_IDLE;
                x_en_q     <= 1'b0;
                busy_q     <= 1'b0;
                in_ready_q <= 1'b1;
              end else begin
                state_q <= S_GAP;
              end
            end
          end
          S_GAP: begin
            if (bit_q == GAP_LAST) begin
              state_q    <= S_IDLE;
              bit_q      <= '0;
              x_en_q     <= 1'b0;
              busy_q     <= 1'b0;
              in_ready_q <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign x_out      = x_out_q;
  assign x_en       = x_en_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: vector table for reset/idle and one frame, plus
// hand-written sequences for back-to-back accepts, BIT_DIV=4, mid-frame reset and detection.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data, in_data4;
  logic       in_valid, in_valid4;
  logic       in_ready, x_out, x_en, busy, frame_done;
  logic       in_ready4, x_out4, x_en4, busy4, frame_done4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seq_pattern_tx dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .x_out(x_out), .x_en(x_en), .busy(busy), .frame_done(frame_done)
  );

  seq_pattern_tx #(.BIT_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .in_data(in_data4), .in_valid(in_valid4),
    .in_ready(in_ready4), .x_out(x_out4), .x_en(x_en4), .busy(busy4), .frame_done(frame_done4)
  );

  typedef struct {
    logic       vld;
    logic [7:0] data;
    logic       x, en, bsy, fd, rdy;
  } vec_t;

  vec_t vecs [24];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Sends one word on the BIT_DIV=1 instance and records the 13 frame cycles.
  task automatic send_capture(input logic [7:0] d, output logic [12:0] xs,
                              output logic [12:0] ens, output logic [12:0] fds,
                              output logic rdy_after);
    xs = '0; ens = '0; fds = '0;
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = ~d;
    for (int k = 0; k < 13; k++) begin
      xs  = {xs[11:0], x_out};
      ens = {ens[11:0], x_en};
      fds = {fds[11:0], frame_done};
      tick();
    end
    rdy_after = in_ready;
  endtask

  // Overlapping "101" Mealy detector: returns {z, next_state}.
  function automatic logic [2:0] det_step(input logic [1:0] st, input logic x);
    case (st)
      2'd0:    det_step = x ? 3'b0_01 : 3'b0_00;
      2'd1:    det_step = x ? 3'b0_01 : 3'b0_10;
      2'd2:    det_step = x ? 3'b1_01 : 3'b0_00;
      default: det_step = 3'b0_00;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [12:0] a5_bits, xs, ens, fds, bits4;
    logic        rdy_after;
    int          acc [2];
    int          n_acc, fd_edge, e_x, e_en, e_bsy, e_fd, len4, z_cnt, z_pos;
    logic [1:0]  dst;
    logic [2:0]  dr;

    a5_bits = 13'b1011010010100;
    for (int i = 0; i < 24; i++) vecs[i] = '{vld: 1'b0, data: 8'h00, x: 1'b0, en: 1'b0, bsy: 1'b0, fd: 1'b0, rdy: 1'b1};
    vecs[10] = '{vld: 1'b1, data: 8'hA5, x: 1'b1, en: 1'b1, bsy: 1'b1, fd: 1'b0, rdy: 1'b0};
    for (int i = 11; i <= 22; i++)
      vecs[i] = '{vld: (i >= 12 && i <= 15), data: 8'h3C, x: a5_bits[22-i], en: 1'b1,
                  bsy: 1'b1, fd: (i == 22), rdy: 1'b0};

    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_valid4 = 1'b0; in_data4 = 8'h00;
    @(negedge clk); @(negedge clk);
    check("reset_state", {x_out, x_en, busy, frame_done, in_ready}, 5'b00001);
    reset = 1'b0;

    // Idle after reset, then 0xA5 with ignored in_valid pulses mid-frame.
    for (int i = 0; i < 24; i++) begin
      in_valid = vecs[i].vld;
      in_data  = vecs[i].data;
      tick();
      check($sformatf("vec[%0d]", i), {x_out, x_en, busy, frame_done, in_ready},
            {vecs[i].x, vecs[i].en, vecs[i].bsy, vecs[i].fd, vecs[i].rdy});
    end
    in_valid = 1'b0;

    // in_valid held high: 0xFF then 0x00 queued.
    n_acc = 0; fd_edge = -1; acc[0] = -1; acc[1] = -1;
    in_valid = 1'b1; in_data = 8'hFF;
    for (int n = 0; n < 60 && n_acc < 2; n++) begin
      logic will;
      will = in_ready;
      tick();
      if (will) begin
        acc[n_acc] = n;
        n_acc++;
        in_data = 8'h00;
      end
      if (frame_done && fd_edge < 0) fd_edge = n;
    end
    in_valid = 1'b0;
    check("t3_accept_count", n_acc, 2);
    check("t3_accept_spacing", acc[1] - acc[0], 14);
    check("t3_first_done_edge", fd_edge - acc[0], 12);
    check("t3_second_after_done", acc[1] > fd_edge, 1'b1);
    xs = '0;
    xs = {xs[11:0], x_out};
    for (int k = 1; k < 13; k++) begin
      tick();
      xs = {xs[11:0], x_out};
    end
    check("t3_frame2_bits", xs, 13'b1010000000000);
    begin
      int w;
      w = 0;
      while (!in_ready && w < 5) begin tick(); w++; end
      check("t3_return_idle", in_ready, 1'b1);
    end

    // BIT_DIV=4 instance, payload 0x80.
    bits4 = 13'b1011000000000;
    e_x = 0; e_en = 0; e_bsy = 0; e_fd = 0; len4 = -1;
    in_valid4 = 1'b1; in_data4 = 8'h80;
    tick();
    in_valid4 = 1'b0;
    for (int k = 0; k < 53; k++) begin
      if (k < 52) begin
        if (x_out4 !== bits4[12 - k/4]) e_x++;
        if (x_en4 !== (k % 4 == 0)) e_en++;
        if (busy4 !== 1'b1) e_bsy++;
        if (frame_done4 !== (k == 51)) e_fd++;
      end
      if (!busy4 && len4 < 0) len4 = k;
      if (k < 52) tick();
    end
    check("t4_x_out_errs", e_x, 0);
    check("t4_x_en_errs", e_en, 0);
    check("t4_busy_errs", e_bsy, 0);
    check("t4_frame_done_errs", e_fd, 0);
    check("t4_frame_len", len4, 52);
    check("t4_end_state", {x_out4, x_en4, frame_done4, in_ready4}, 4'b0001);

    // Reset during the 5th payload bit of 0x0F (a '1' bit).
    in_valid = 1'b1; in_data = 8'h0F;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    check("t5_before_reset", {x_out, busy}, 2'b11);
    reset = 1'b1;
    #1;
    check("t5_in_reset", {x_out, x_en, busy, frame_done, in_ready}, 5'b00001);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("t5_after_release", {busy, in_ready}, 2'b01);
    send_capture(8'h3C, xs, ens, fds, rdy_after);
    check("t5_next_frame_bits", xs, 13'b1010011110000);
    check("t5_next_frame_en", ens, 13'h1FFF);
    check("t5_next_frame_done", fds, 13'h0001);
    check("t5_ready_after", rdy_after, 1'b1);

    // x_out looped into a "101" detector, payload 0x00.
    send_capture(8'h00, xs, ens, fds, rdy_after);
    dst = 2'd0; z_cnt = 0; z_pos = -1;
    for (int k = 0; k < 3; k++) begin
      dr = det_step(dst, 1'b0);
      dst = dr[1:0];
    end
    for (int k = 0; k < 13; k++) begin
      dr = det_step(dst, xs[12-k]);
      dst = dr[1:0];
      if (dr[2]) begin z_cnt++; z_pos = k; end
    end
    check("t6_z_count", z_cnt, 1);
    check("t6_z_position", z_pos, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
